// File: rtl/nibble_stim_tx.sv
// Paired 4-bit stimulus source: incrementing stream on data_in, saturating decrementing
// stream on decre_in, offered with enable and accepted by next, in bursts of latched length.
module nibble_stim_tx #(
  parameter int unsigned INC_MIN = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clock1,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       inc_seed,
  input  logic [3:0]       dec_seed,
  input  logic [CNT_W-1:0] beats,
  input  logic             next,
  output logic             enable,
  output logic [3:0]       data_in,
  output logic [3:0]       decre_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_cnt
);

  typedef enum logic [1:0] {StIdle, StSend, StFin} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] beats_q;
  logic             xfer;
  logic [CNT_W-1:0] sent_inc;
  logic [3:0]       data_adv;
  logic [3:0]       decre_adv;

  assign xfer     = enable && next;
  assign sent_inc = sent_cnt + CNT_W'(1);

  // Values below the threshold hold; 15 wraps to 0, which then sits below the threshold.
  always_comb begin
    data_adv  = data_in;
    decre_adv = decre_in;
    if (32'(data_in) >= INC_MIN) data_adv = data_in + 4'd1;
    if (decre_in != 4'd0) decre_adv = decre_in - 4'd1;
  end

  always_ff @(posedge clock1) begin
    if (rst) begin
      state_q  <= StIdle;
      beats_q  <= '0;
      enable   <= 1'b0;
      data_in  <= 4'd0;
      decre_in <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sent_cnt <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          enable <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
          if (start && !abort) begin
            beats_q  <= beats;
            sent_cnt <= '0;
            data_in  <= inc_seed;
            decre_in <= dec_seed;
            busy     <= 1'b1;
            if (beats == '0) begin
              state_q <= StFin;
              done    <= 1'b1;
            end else begin
              state_q <= StSend;
              enable  <= 1'b1;
            end
          end
        end
        StSend: begin
          if (xfer) begin
            sent_cnt <= sent_inc;
            data_in  <= data_adv;
            decre_in <= decre_adv;
          end
          // Abort wins over completion, even on the final transfer.
          if (abort) begin
            state_q <= StIdle;
            enable  <= 1'b0;
            busy    <= 1'b0;
          end else if (xfer && sent_inc == beats_q) begin
            state_q <= StFin;
            enable  <= 1'b0;
            done    <= 1'b1;
          end
        end
        StFin: begin
          state_q <= StIdle;
          enable  <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          enable  <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_stim_tx.sv
// Self-checking bench for nibble_stim_tx: directed bursts then randomized bursts, checked
// against closed-form per-beat expectations.
module tb_nibble_stim_tx;

  localparam int unsigned IncMin = 4;
  localparam int unsigned CntW   = 8;

  logic            clock1 = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [3:0]      inc_seed = 4'd0;
  logic [3:0]      dec_seed = 4'd0;
  logic [CntW-1:0] beats = '0;
  logic            next = 1'b0;
  logic            enable;
  logic [3:0]      data_in;
  logic [3:0]      decre_in;
  logic            busy;
  logic            done;
  logic [CntW-1:0] sent_cnt;

  int errors = 0;
  int checks = 0;

  nibble_stim_tx #(
    .INC_MIN(IncMin),
    .CNT_W  (CntW)
  ) dut (
    .clock1  (clock1),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .inc_seed(inc_seed),
    .dec_seed(dec_seed),
    .beats   (beats),
    .next    (next),
    .enable  (enable),
    .data_in (data_in),
    .decre_in(decre_in),
    .busy    (busy),
    .done    (done),
    .sent_cnt(sent_cnt)
  );

  always #5 clock1 = ~clock1;

  // Value of the incrementing stream after k transfers from seed.
  function automatic int inc_at(input int seed, input int k);
    if (seed < int'(IncMin)) return seed;
    if (seed + k <= 15) return seed + k;
    return 0;
  endfunction

  function automatic int dec_at(input int seed, input int k);
    return (seed > k) ? seed - k : 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock1);
    #1;
  endtask

  // One burst. use_pat selects next from pat bits (else random); abort_at < 0 disables abort;
  // noise drives conflicting start requests while the burst is busy.
  task automatic run_burst(input int is, input int ds, input int nb, input bit use_pat,
                           input logic [31:0] pat, input int abort_at, input bit noise);
    int k;
    int cyc;
    bit nx;
    inc_seed = 4'(is);
    dec_seed = 4'(ds);
    beats    = CntW'(nb);
    start    = 1'b1;
    step();
    start = 1'b0;
    beats = CntW'($urandom_range(0, 255));
    chk("busy_after_start", int'(busy), 1);
    if (nb == 0) begin
      chk("zero_done", int'(done), 1);
      chk("zero_enable", int'(enable), 0);
      step();
      chk("zero_idle_busy", int'(busy), 0);
      chk("zero_idle_done", int'(done), 0);
      return;
    end
    k = 0;
    cyc = 0;
    while (k < nb) begin
      if (cyc > 4 * nb + 64) begin
        chk("burst_timeout", k, nb);
        return;
      end
      chk("send_enable", int'(enable), 1);
      chk("send_busy", int'(busy), 1);
      chk("send_done", int'(done), 0);
      chk("send_data", int'(data_in), inc_at(is, k));
      chk("send_decre", int'(decre_in), dec_at(ds, k));
      chk("send_sent", int'(sent_cnt), k);
      nx = use_pat ? pat[cyc % 32] : 1'($urandom_range(0, 1));
      next = nx;
      if (noise) begin
        start    = 1'($urandom_range(0, 1));
        inc_seed = 4'($urandom_range(0, 15));
        dec_seed = 4'($urandom_range(0, 15));
      end
      if (k == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        next  = 1'b0;
        if (nx) k++;
        chk("abort_enable", int'(enable), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_sent", k, int'(sent_cnt));
        return;
      end
      step();
      if (nx) k++;
      cyc++;
    end
    start = 1'b0;
    next  = 1'($urandom_range(0, 1));
    chk("fin_enable", int'(enable), 0);
    chk("fin_done", int'(done), 1);
    chk("fin_busy", int'(busy), 1);
    chk("fin_sent", int'(sent_cnt), nb);
    chk("fin_data", int'(data_in), inc_at(is, nb));
    chk("fin_decre", int'(decre_in), dec_at(ds, nb));
    step();
    next = 1'b0;
    chk("post_done", int'(done), 0);
    chk("post_busy", int'(busy), 0);
    chk("post_sent", int'(sent_cnt), nb);
  endtask

  initial begin
    int is;
    int ds;
    int nb;
    int ab;
    step();
    step();
    rst = 1'b0;
    chk("rst_enable", int'(enable), 0);
    chk("rst_data", int'(data_in), 0);
    chk("rst_decre", int'(decre_in), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sent", int'(sent_cnt), 0);

    // Start together with abort is ignored.
    start = 1'b1;
    abort = 1'b1;
    beats = 8'd3;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", int'(busy), 0);
    chk("start_abort_enable", int'(enable), 0);

    run_burst(10, 12, 5, 1'b1, 32'hFFFF_FFFF, -1, 1'b0);
    run_burst(14, 2, 4, 1'b1, 32'hFFFF_FFFF, -1, 1'b0);
    run_burst(3, 9, 3, 1'b1, 32'hFFFF_FFFF, -1, 1'b0);
    run_burst(7, 5, 3, 1'b1, 32'h0000_0029, -1, 1'b0);
    run_burst(6, 15, 6, 1'b1, 32'hFFFF_FFFF, 2, 1'b0);
    run_burst(5, 5, 0, 1'b1, 32'hFFFF_FFFF, -1, 1'b0);
    run_burst(4, 4, 4, 1'b1, 32'hFFFF_FFFF, 3, 1'b0);
    run_burst(9, 11, 6, 1'b0, 32'h0, -1, 1'b1);

    // Reset mid-burst clears every output.
    inc_seed = 4'd8;
    dec_seed = 4'd8;
    beats    = 8'd10;
    start    = 1'b1;
    next     = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst  = 1'b0;
    next = 1'b0;
    chk("midrst_enable", int'(enable), 0);
    chk("midrst_data", int'(data_in), 0);
    chk("midrst_decre", int'(decre_in), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_sent", int'(sent_cnt), 0);

    for (int i = 0; i < 25; i++) begin
      is = int'($urandom_range(0, 15));
      ds = int'($urandom_range(0, 15));
      nb = int'($urandom_range(0, 12));
      ab = ($urandom_range(0, 3) == 0 && nb > 0) ? int'($urandom_range(0, nb - 1)) : -1;
      run_burst(is, ds, nb, 1'b0, 32'h0, ab, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
